// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one word-wide data memory between two requesters,
// with sub-word stores as read-modify-write and RISC-V load extension. Optional byte-enable build: DMEM_ARB_BYTE_WE_EN.
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0]                 req_we,
    input  logic [1:0][2:0]            req_funct3,
    input  logic [1:0][DM_ADDRESS-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0]     req_wdata,
    output logic [1:0]                 rsp_valid,
    input  logic [1:0]                 rsp_ready,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic [DM_ADDRESS-1:0]      mem_addr,
    output logic                       mem_re,
    output logic                       mem_we,
    output logic [DATA_W-1:0]          mem_wdata,
`ifdef DMEM_ARB_BYTE_WE_EN
    output logic [3:0]                 mem_be,
`endif
    input  logic [DATA_W-1:0]          mem_rdata
);

`ifdef DMEM_ARB_BYTE_WE_EN
    localparam bit BYTE_WE = 1'b1;
`else
    localparam bit BYTE_WE = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RD, WR, MERGE, RESP} state_t;

    state_t                state_q, state_d;
    logic                  last_q, last_d, gnt_q, gnt_d, we_q, we_d;
    logic                  err_q, err_d, ld_pend_q, ld_pend_d;
    logic [2:0]            f3_q, f3_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;

    logic                  gnt_sel, legal;
    logic [2:0]            sel_f3;
    logic [1:0]            sel_lo;
    logic [DATA_W-1:0]     shifted, load_ext, merged;
    logic [7:0]            byte_s;
    logic [15:0]           half_s;

    assign gnt_sel = (&req_valid) ? ~last_q : req_valid[1];
    assign sel_f3  = req_funct3[gnt_sel];
    assign sel_lo  = req_addr[gnt_sel][1:0];

    always_comb begin
        legal = 1'b0;
        case (sel_f3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~sel_lo[0];
            3'b010:  legal = (sel_lo == 2'b00);
            3'b100:  legal = ~req_we[gnt_sel];
            3'b101:  legal = ~req_we[gnt_sel] & ~sel_lo[0];
            default: legal = 1'b0;
        endcase
    end

    // Load extraction and RMW merge both work on the word returned one cycle after RD.
    assign shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    assign byte_s  = shifted[7:0];
    assign half_s  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_ext = mem_rdata;
        case (f3_q)
            3'b000:  load_ext = {{24{byte_s[7]}}, byte_s};
            3'b001:  load_ext = {{16{half_s[15]}}, half_s};
            3'b100:  load_ext = {24'd0, byte_s};
            3'b101:  load_ext = {16'd0, half_s};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        if (f3_q[0]) begin
            if (addr_q[1]) merged[31:16] = wdata_q[15:0];
            else           merged[15:0]  = wdata_q[15:0];
        end else begin
            case (addr_q[1:0])
                2'b00:   merged[7:0]   = wdata_q[7:0];
                2'b01:   merged[15:8]  = wdata_q[7:0];
                2'b10:   merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        we_d      = we_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        ld_pend_d = ld_pend_q;
        req_ready = 2'b00;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[gnt_sel] = 1'b1;
                    gnt_d     = gnt_sel;
                    last_d    = gnt_sel;
                    we_d      = req_we[gnt_sel];
                    f3_d      = sel_f3;
                    addr_d    = req_addr[gnt_sel];
                    wdata_d   = req_wdata[gnt_sel];
                    err_d     = ~legal;
                    rdata_d   = '0;
                    ld_pend_d = 1'b0;
                    if (!legal)                                    state_d = RESP;
                    else if (!req_we[gnt_sel])                     state_d = RD;
                    else if (sel_f3 == 3'b010 || BYTE_WE)          state_d = WR;
                    else                                           state_d = RD;
                end
            end
            RD: begin
                if (we_q) begin
                    state_d = MERGE;
                end else begin
                    state_d   = RESP;
                    ld_pend_d = 1'b1;
                end
            end
            WR, MERGE: state_d = RESP;
            RESP: begin
                // Freeze the extended load on the first RESP cycle so it stays stable under backpressure.
                if (ld_pend_q) begin
                    rdata_d   = load_ext;
                    ld_pend_d = 1'b0;
                end
                if (rsp_ready[gnt_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            ld_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            we_q      <= we_d;
            f3_q      <= f3_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            ld_pend_q <= ld_pend_d;
        end
    end

    assign mem_re    = (state_q == RD);
    assign mem_we    = (state_q == WR) || (state_q == MERGE);
    assign mem_addr  = (mem_re || mem_we) ? {addr_q[DM_ADDRESS-1:2], 2'b00} : '0;
    assign rsp_rdata = (state_q == RESP) ? (ld_pend_q ? load_ext : rdata_q) : '0;
    assign rsp_err   = (state_q == RESP) && err_q;

    always_comb begin
        rsp_valid = 2'b00;
        if (state_q == RESP) rsp_valid[gnt_q] = 1'b1;
    end

    always_comb begin
        mem_wdata = '0;
        if (state_q == MERGE) begin
            mem_wdata = merged;
        end else if (state_q == WR) begin
            case (f3_q)
                3'b000:  mem_wdata = {4{wdata_q[7:0]}};
                3'b001:  mem_wdata = {2{wdata_q[15:0]}};
                default: mem_wdata = wdata_q;
            endcase
        end
    end

`ifdef DMEM_ARB_BYTE_WE_EN
    always_comb begin
        mem_be = 4'b0000;
        if (state_q == WR) begin
            case (f3_q)
                3'b000:  mem_be = 4'b0001 << addr_q[1:0];
                3'b001:  mem_be = 4'b0011 << addr_q[1:0];
                default: mem_be = 4'b1111;
            endcase
        end else if (state_q == MERGE) begin
            mem_be = 4'b1111;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: handshake observer pushes expected responses, monitor pops and compares.
module tb_dmem_arbiter;
    localparam int AW = 9;
`ifdef DMEM_ARB_BYTE_WE_EN
    localparam bit BWE = 1'b1;
`else
    localparam bit BWE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [1:0]          req_valid, req_ready, req_we, rsp_valid, rsp_ready;
    logic [1:0][2:0]     req_funct3;
    logic [1:0][AW-1:0]  req_addr;
    logic [1:0][31:0]    req_wdata;
    logic [31:0]         rsp_rdata, mem_wdata, mem_rdata;
    logic                rsp_err, mem_re, mem_we;
    logic [AW-1:0]       mem_addr;
`ifdef DMEM_ARB_BYTE_WE_EN
    logic [3:0]          mem_be;
`endif
    logic [3:0]          last_be;

    dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
`ifdef DMEM_ARB_BYTE_WE_EN
        .mem_be(mem_be),
`endif
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    int          grant_log[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          nre = 0;
    int          nwe = 0;
    logic [31:0] exp_rdata [2];
    logic        exp_err [2];
    logic        exp_en [2];
    logic [31:0] mem [128];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Word memory with one-cycle read latency.
    initial begin
        foreach (mem[i]) mem[i] = 32'h0;
        mem[4]    = 32'h8899AABB;
        mem[8]    = 32'h11223344;
        mem[12]   = 32'hCAFEF00D;
        mem[16]   = 32'h80011234;
        mem_rdata = 32'h0;
        last_be   = 4'h0;
        forever begin
            @(posedge clk);
            if (mem_we) begin
                nwe++;
`ifdef DMEM_ARB_BYTE_WE_EN
                last_be = mem_be;
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr[AW-1:2]][8*b +: 8] = mem_wdata[8*b +: 8];
`else
                mem[mem_addr[AW-1:2]] = mem_wdata;
`endif
            end
            if (mem_re) begin
                nre++;
                mem_rdata <= mem[mem_addr[AW-1:2]];
            end
        end
    end

    // Handshake observer and response monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            check("strobe_excl", {31'd0, mem_re & mem_we}, 32'd0);
            check("ready_while_rsp", {31'd0, (rsp_valid != 2'b00) && (req_ready != 2'b00)}, 32'd0);
            for (int p = 0; p < 2; p++) begin
                if (req_valid[p] && req_ready[p]) begin
                    check("grant_when_idle", sbq.size(), 32'd0);
                    grant_log.push_back(p);
                    if (exp_en[p]) sbq.push_back('{port: p, rdata: exp_rdata[p], err: exp_err[p]});
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (rsp_valid[p] && rsp_ready[p]) begin
                    if (sbq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_rsp: port %0d rdata 0x%08h, expected no response", p, rsp_rdata);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        check("rsp_port", p, e.port);
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    end
                end
            end
        end
    end

    task automatic do_req(input int p, input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                          input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                          input int elat, input string name);
        int  n;
        bit  got;
        exp_rdata[p] = erd;
        exp_err[p]   = eerr;
        exp_en[p]    = 1'b1;
        req_we[p]     = we;
        req_funct3[p] = f3;
        req_addr[p]   = a;
        req_wdata[p]  = wd;
        req_valid[p]  = 1'b1;
        got = 1'b0;
        n   = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (req_ready[p]) begin
                got = 1'b1;
                n   = cyc;
            end
        end
        if (!got) begin
            timeout({name, "_grant"});
            req_valid[p] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid[p] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid[p]) got = 1'b1;
        end
        if (got) check({name, "_lat"}, cyc - n, elat);
        else     timeout({name, "_rsp"});
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && (sbq.size() != 0 || rsp_valid != 2'b00); i++) @(negedge clk);
        check({name, "_drain"}, sbq.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r0, w0;
        bit got;
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        req_we     = 2'b00;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 2'b11;
        exp_en[0] = 1'b0; exp_en[1] = 1'b0;
        exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
        exp_err[0] = 1'b0; exp_err[1] = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_mem_strobes", {30'd0, mem_re, mem_we}, 32'd0);
        check("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;

        // Both ports requesting continuously: grants must alternate starting with port 0.
        exp_rdata[0] = 32'h8899AABB; exp_rdata[1] = 32'h8899AABB;
        exp_en[0] = 1'b1; exp_en[1] = 1'b1;
        req_funct3[0] = 3'b010; req_funct3[1] = 3'b010;
        req_addr[0] = 9'h010; req_addr[1] = 9'h010;
        req_valid = 2'b11;
        for (int i = 0; i < 100 && grant_log.size() < 4; i++) @(negedge clk);
        @(posedge clk);
        #1 req_valid = 2'b00;
        drain("alt");
        if (grant_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("alt_grant", grant_log[i], i % 2);
        end else timeout("alt_grants");
        grant_log.delete();

        do_req(0, 1'b0, 3'b000, 9'h011, 32'h0, 32'hFFFFFFAA, 1'b0, 2, "lb");
        do_req(0, 1'b0, 3'b100, 9'h011, 32'h0, 32'h000000AA, 1'b0, 2, "lbu");
        do_req(1, 1'b0, 3'b001, 9'h012, 32'h0, 32'hFFFF8899, 1'b0, 2, "lh");
        do_req(1, 1'b0, 3'b101, 9'h010, 32'h0, 32'h0000AABB, 1'b0, 2, "lhu");

        r0 = nre; w0 = nwe;
        do_req(0, 1'b1, 3'b000, 9'h022, 32'h000000EE, 32'h0, 1'b0, BWE ? 2 : 3, "sb");
        check("sb_reads", nre - r0, BWE ? 0 : 1);
        check("sb_writes", nwe - w0, 1);
        check("sb_mem", mem[8], 32'h11EE3344);
`ifdef DMEM_ARB_BYTE_WE_EN
        check("sb_be", {28'd0, last_be}, 32'h4);
`endif

        r0 = nre; w0 = nwe;
        do_req(1, 1'b0, 3'b010, 9'h006, 32'h0, 32'h0, 1'b1, 1, "lw_misaligned");
        do_req(1, 1'b1, 3'b100, 9'h020, 32'h0, 32'h0, 1'b1, 1, "st_bad_f3");
        do_req(0, 1'b1, 3'b001, 9'h021, 32'h0, 32'h0, 1'b1, 1, "sh_misaligned");
        check("err_no_access", (nre - r0) + (nwe - w0), 0);

        do_req(1, 1'b1, 3'b001, 9'h052, 32'h5555BEEF, 32'h0, 1'b0, BWE ? 2 : 3, "sh");
        check("sh_mem", mem[20], 32'hBEEF0000);
        do_req(0, 1'b1, 3'b010, 9'h054, 32'hDEADBEEF, 32'h0, 1'b0, 2, "sw");
        do_req(0, 1'b0, 3'b001, 9'h052, 32'h0, 32'hFFFFBEEF, 1'b0, 2, "lh_back");
        do_req(1, 1'b0, 3'b010, 9'h054, 32'h0, 32'hDEADBEEF, 1'b0, 2, "lw_back");

        // Response backpressure with the other port waiting.
        rsp_ready[0] = 1'b0;
        do_req(0, 1'b0, 3'b101, 9'h042, 32'h0, 32'h00008001, 1'b0, 2, "lhu_hold");
        exp_rdata[1] = 32'h8899AABB; exp_err[1] = 1'b0;
        req_we[1] = 1'b0; req_funct3[1] = 3'b010; req_addr[1] = 9'h010; req_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {30'd0, rsp_valid}, 32'h1);
            check("hold_rdata", rsp_rdata, 32'h00008001);
            check("hold_ready", {30'd0, req_ready}, 32'd0);
        end
        rsp_ready[0] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready[1]) got = 1'b1;
        end
        if (!got) timeout("hold_next_grant");
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        drain("hold");

        // Reset while the SH write strobe is up: no write, no response.
        exp_en[0] = 1'b0;
        req_we[0] = 1'b1; req_funct3[0] = 3'b001; req_addr[0] = 9'h032; req_wdata[0] = 32'h00001234;
        req_valid[0] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (mem_we) got = 1'b1;
        end
        if (!got) timeout("rstmid_we");
        req_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rstmid_mem_we", {30'd0, mem_re, mem_we}, 32'd0);
        @(negedge clk);
        check("rstmid_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_mem", mem[12], 32'hCAFEF00D);
        grant_log.delete();
        exp_rdata[0] = 32'hCAFEF00D; exp_rdata[1] = 32'hCAFEF00D;
        exp_err[0] = 1'b0; exp_err[1] = 1'b0;
        exp_en[0] = 1'b1; exp_en[1] = 1'b1;
        req_we = 2'b00; req_funct3[0] = 3'b010; req_funct3[1] = 3'b010;
        req_addr[0] = 9'h030; req_addr[1] = 9'h030;
        req_valid = 2'b11;
        @(negedge clk);
        check("rstmid_first_grant", {30'd0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid = 2'b00;
        drain("rstmid");
        check("rstmid_grants", grant_log.size(), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port word-organised data memory between two requesters: port 0 (core load/store unit) and port 1 (DMA/debug).
- Round-robin arbitration with valid/ready request and response handshakes.
- Memory side is word-wide with a single write strobe, so the block sequences sub-word stores as read-modify-write.
- Performs load sign/zero extension using RISC-V Funct3 size encoding.

Parameters:
- DM_ADDRESS, 9, byte-address width of the memory
- DATA_W, 32, data width; fixed at 32

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-port request valid; bit i = port i
- req_ready  out  2  per-port request accept
- req_we  in  2  per-port: 1 = store, 0 = load
- req_funct3  in  2x3  per-port size code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- req_addr  in  2xDM_ADDRESS  per-port byte address
- req_wdata  in  2x32  per-port store data; low bits used for SB/SH
- rsp_valid  out  2  per-port response valid
- rsp_ready  in  2  per-port response accept
- rsp_rdata  out  32  extended load data; 0 for stores
- rsp_err  out  1  misaligned address or illegal funct3
- mem_addr  out  DM_ADDRESS  word-aligned address; bits [1:0] always 0
- mem_re  out  1  memory read strobe; data valid on mem_rdata next cycle
- mem_we  out  1  memory word write strobe
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data; 1-cycle latency

Behaviour:
- FSM states: IDLE, RD, WR, MERGE, RESP.
- Reset (asynchronous, immediate): state=IDLE; last_grant=1; req_ready=0; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_re=0; mem_we=0; mem_addr=0; mem_wdata=0.
- Arbitration, IDLE only:
  - Single valid port is granted.
  - Both valid: grant the port != last_grant.
  - req_ready[g]=1 combinationally for the granted port only; the other port's ready=0.
  - On handshake, capture we/funct3/addr/wdata and set last_grant=g.
- Legality check at accept:
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=0.
  - Stores only permit funct3 000/001/010.
  - Illegal request → RESP next cycle with rsp_err=1, rsp_rdata=0, no memory access.
- Load path: accept (cycle N) → RD at N+1 (mem_re=1, mem_addr={addr[msb:2],2'b00}) → RESP at N+2.
  - Byte select addr[1:0]; halfword select addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- SW path: N → WR at N+1 (mem_we=1, mem_wdata=wdata) → RESP at N+2.
- SB/SH path: N → RD at N+1 → MERGE at N+2 → RESP at N+3.
  - MERGE: mem_we=1 with mem_rdata, target byte/half replaced by wdata[7:0]/[15:0].
  - Untouched bytes are preserved exactly.
- RESP:
  - rsp_valid[g]=1 held, with rsp_rdata/rsp_err stable, until rsp_ready[g]=1.
  - Then return to IDLE; a new grant is possible the next cycle.
  - rsp_valid[other]=0 throughout.
- Busy (any state except IDLE): req_ready=0; requests wait.
- mem_re and mem_we are never asserted together; each is asserted for exactly one cycle per access.
- Reset mid-operation: transaction dropped, memory strobes drop immediately, no response issued. A partial RMW (RD done, MERGE not reached) leaves memory unchanged.
- Port 1 requests are treated identically to port 0; no priority beyond round-robin.

Optional Feature:
- Macro DMEM_ARB_BYTE_WE_EN.
- When defined:
  - Adds output mem_be[3:0].
  - SB/SH take the SW path: WR at N+1 with mem_be = 0001<<addr[1:0] (SB) or 0011<<addr[1:0] (SH), wdata replicated across lanes; RESP at N+2. No MERGE state.
  - SW/MERGE writes use mem_be=1111.
- When undefined: no mem_be port; RMW sequencing as above.

Test Plan:
- Memory word 0x10 = 0x8899AABB; port0 LB addr 0x11 → rsp at N+2, rsp_rdata=0xFFFFFFAA, err=0; LBU same addr → 0x000000AA.
- Word 0x20 = 0x11223344; port0 SB addr 0x22 wdata 0x000000EE → exactly one mem_re then one mem_we; memory=0x11EE3344; rsp at N+3 (N+2 with DMEM_ARB_BYTE_WE_EN, mem_be=0100).
- Both ports valid every cycle from reset → grants alternate 0,1,0,1; each grant only after the previous response handshake.
- Port1 LW addr 0x06 → rsp_err=1 at N+1; mem_re and mem_we stay 0.
- Hold rsp_ready=0 for 5 cycles after an LHU of 0x8001 → rsp_valid and rsp_rdata=0x00008001 stable; req_ready=0 throughout.
- rst_n low during MERGE cycle of SH → mem_we falls immediately; memory unchanged; after release state=IDLE, port0 wins first grant.
